// File: rtl/apb_slave_mem.sv
// APB slave with a DEPTH x DATA_W RAM, fixed WAIT_CYC wait states per access.
// Optional `APB_SLVERR_EN` adds pslverr_o for out-of-range or zero-strobe accesses.
module apb_slave_mem #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic                pwrite_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o
`ifdef APB_SLVERR_EN
  ,
  output logic                pslverr_o
`endif
);

  localparam int NB   = DATA_W / 8;
  localparam int OFF  = $clog2(NB);
  localparam int IDXW = ADDR_W - OFF;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDXW:0] DEPTH_L = (IDXW+1)'(DEPTH);
  localparam logic [3:0]    WAIT_L  = 4'(WAIT_CYC);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_strb;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDXW-1:0]   w_idx;
  logic              w_setup;
  logic              w_active;
  logic              w_in_rng;
  logic              w_r_in_rng;
  logic              w_done;
  logic              w_we;

  assign w_idx      = paddr_i[ADDR_W-1:OFF];
  assign w_setup    = psel_i & ~penable_i;
  assign w_active   = psel_i & penable_i;
  assign w_in_rng   = ({1'b0, w_idx} < DEPTH_L);
  assign w_r_in_rng = ({1'b0, r_idx} < DEPTH_L);
  // Ready is a pure decode of registered state; no input reaches it.
  assign w_done     = (r_state == ACCESS) && (r_cnt == WAIT_L);
  // Gating with reset drops a write whose completion edge coincides with reset.
  assign w_we       = w_done & w_active & r_write & w_r_in_rng & reset;

  assign pready_o = w_done;
  assign prdata_o = r_rdata;

`ifdef APB_SLVERR_EN
  logic r_err;
  assign pslverr_o = w_done & r_err;
`endif

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < NB; b++) begin
        if (r_strb[b]) r_mem[r_idx[AW-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
`ifdef APB_SLVERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_idx   <= w_idx;
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
            r_strb  <= pstrb_i;
            r_cnt   <= '0;
            r_state <= ACCESS;
`ifdef APB_SLVERR_EN
            r_err   <= ~w_in_rng | (pwrite_i & ~|pstrb_i);
`endif
            // Reads fetch at the setup edge so data is stable for all of ACCESS.
            if (!pwrite_i) r_rdata <= w_in_rng ? r_mem[w_idx[AW-1:0]] : '0;
          end
        end
        ACCESS: begin
          if (!w_active || w_done) r_state <= IDLE;
          else                     r_cnt   <= r_cnt + 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
